// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the RV32IF pipeline datapath and its central stall/flush sequencer.
// master = datapath side (drives hazard sources), slave = sequencer side (drives register selects).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_rs1_is_f;
  logic             id_rs2_is_f;
  logic [4:0]       ex_rd_addr;
  logic             ex_rd_wren_I;
  logic             ex_rd_wren_F;
  logic             ex_is_load;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic [1:0]       sel_if_id;
  logic [1:0]       sel_id_ex;
  logic [1:0]       sel_ex_mem;
  logic [1:0]       sel_mem_wb;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state_o;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rs1_is_f, id_rs2_is_f,
    output ex_rd_addr, ex_rd_wren_I, ex_rd_wren_F, ex_is_load, ex_br_taken, mem_req, mem_ack,
    input  pc_en, sel_if_id, sel_id_ex, sel_ex_mem, sel_mem_wb,
    input  err_timeout, stall_cnt, flush_cnt, state_o
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rs1_is_f, id_rs2_is_f,
    input  ex_rd_addr, ex_rd_wren_I, ex_rd_wren_F, ex_is_load, ex_br_taken, mem_req, mem_ack,
    output pc_en, sel_if_id, sel_id_ex, sel_ex_mem, sel_mem_wb,
    output err_timeout, stall_cnt, flush_cnt, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IF pipeline: load-use, branch redirect and
// slow-MEM waits, with a bounded wait timer and saturating stall/flush debug counters.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 32
) (
  input logic                   i_clk,
  input logic                   i_rst,
  pipeline_hazard_ctrl_if.slave io_hz
);
  // MEM handshake: the MEM stage holds mem_req high for the whole access; the access
  // completes in any cycle where mem_req and mem_ack are both high. A cycle with
  // mem_req=1 and mem_ack=0 is a wait cycle and freezes IF..MEM.

  localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_INIT = 2'b00, S_RUN = 2'b01, S_WAIT = 2'b10} state_t;
  typedef enum logic [2:0] {P_NORMAL, P_LU, P_FLUSH, P_WAIT, P_CLEAR} pat_t;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_CLR  = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_init_cnt;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  pat_t             w_pat;
  pat_t             w_run_pat;
  logic             w_timeout;
  logic             w_rs1_hz;
  logic             w_rs2_hz;
  logic             w_lu;
  logic             w_pc_en;

  // x0 is hard-wired so never hazards; f0 is a real register and does.
  always_comb begin
    w_rs1_hz = io_hz.id_rs1_used && (io_hz.id_rs1_addr == io_hz.ex_rd_addr) &&
               (io_hz.id_rs1_is_f ? io_hz.ex_rd_wren_F
                                  : (io_hz.ex_rd_wren_I && (io_hz.id_rs1_addr != 5'd0)));
    w_rs2_hz = io_hz.id_rs2_used && (io_hz.id_rs2_addr == io_hz.ex_rd_addr) &&
               (io_hz.id_rs2_is_f ? io_hz.ex_rd_wren_F
                                  : (io_hz.ex_rd_wren_I && (io_hz.id_rs2_addr != 5'd0)));
    w_lu      = io_hz.ex_is_load && (w_rs1_hz || w_rs2_hz);
    w_run_pat = io_hz.ex_br_taken ? P_FLUSH : (w_lu ? P_LU : P_NORMAL);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat       = P_CLEAR;
    w_timeout   = 1'b0;
    w_timer_inc = r_timer + 1'b1;
    case (r_state)
      S_INIT: begin
        if (r_init_cnt == IW'(INIT_CYCLES - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (io_hz.mem_req && !io_hz.mem_ack) begin
          w_pat       = P_WAIT;
          w_state_nxt = S_WAIT;
        end else begin
          w_pat = w_run_pat;
        end
      end
      S_WAIT: begin
        if (io_hz.mem_ack) begin
          w_pat       = w_run_pat;
          w_state_nxt = S_RUN;
        end else if ((TIMEOUT != 0) && (w_timer_inc == TW'(TIMEOUT))) begin
          // Forced release: the entry cycle plus TIMEOUT-1 wait cycles have already stalled.
          w_pat       = w_run_pat;
          w_timeout   = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_pat = P_WAIT;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
    if (i_rst) begin
      w_pat     = P_CLEAR;
      w_timeout = 1'b0;
    end
  end

  always_comb begin
    w_pc_en          = 1'b0;
    io_hz.sel_if_id  = SEL_CLR;
    io_hz.sel_id_ex  = SEL_CLR;
    io_hz.sel_ex_mem = SEL_CLR;
    io_hz.sel_mem_wb = SEL_CLR;
    case (w_pat)
      P_NORMAL: begin
        w_pc_en          = 1'b1;
        io_hz.sel_if_id  = SEL_LOAD;
        io_hz.sel_id_ex  = SEL_LOAD;
        io_hz.sel_ex_mem = SEL_LOAD;
        io_hz.sel_mem_wb = SEL_LOAD;
      end
      P_LU: begin
        io_hz.sel_if_id  = SEL_HOLD;
        io_hz.sel_ex_mem = SEL_LOAD;
        io_hz.sel_mem_wb = SEL_LOAD;
      end
      P_FLUSH: begin
        w_pc_en          = 1'b1;
        io_hz.sel_ex_mem = SEL_LOAD;
        io_hz.sel_mem_wb = SEL_LOAD;
      end
      P_WAIT: begin
        io_hz.sel_if_id  = SEL_HOLD;
        io_hz.sel_id_ex  = SEL_HOLD;
        io_hz.sel_ex_mem = SEL_HOLD;
      end
      default: ;
    endcase
    io_hz.pc_en       = w_pc_en;
    io_hz.err_timeout = w_timeout;
    io_hz.stall_cnt   = r_stall_cnt;
    io_hz.flush_cnt   = r_flush_cnt;
    io_hz.state_o     = r_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_timer     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      else                   r_init_cnt <= '0;
      if (r_state == S_WAIT) r_timer <= w_timer_inc;
      else                   r_timer <= '0;
      if (r_state != S_INIT) begin
        if (!w_pc_en && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
        if ((w_pat == P_FLUSH) && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, each cycle's expected outputs computed by a behavioural model and queued.
module tb_pipeline_hazard_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int TIMEOUT     = 8;
  localparam int CNT_W       = 4;
  localparam int W           = 9 + 1 + 2 * CNT_W + 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int P_NORMAL = 0, P_LU = 1, P_FLUSH = 2, P_WAIT = 3, P_CLEAR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  pipeline_hazard_ctrl #(
    .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .io_hz(hz.slave)
  );

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Model: cycles of INIT left, whether a slow access is outstanding, cycles stalled on it.
  int m_init_left = INIT_CYCLES;
  bit m_waiting   = 1'b0;
  int m_waited    = 0;
  int m_stall     = 0;
  int m_flush     = 0;

  function automatic logic [8:0] pat_bits(input int p);
    case (p)
      P_NORMAL: return 9'b1_00_00_00_00;
      P_LU:     return 9'b0_01_11_00_00;
      P_FLUSH:  return 9'b1_11_11_00_00;
      P_WAIT:   return 9'b0_01_01_01_11;
      default:  return 9'b0_11_11_11_11;
    endcase
  endfunction

  function automatic bit model_lu();
    bit hit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [4:0] a    = (s == 0) ? hz.id_rs1_addr : hz.id_rs2_addr;
      logic       used = (s == 0) ? hz.id_rs1_used : hz.id_rs2_used;
      logic       isf  = (s == 0) ? hz.id_rs1_is_f : hz.id_rs2_is_f;
      if (used && a == hz.ex_rd_addr) begin
        if (isf) hit = hit | hz.ex_rd_wren_F;
        else     hit = hit | (hz.ex_rd_wren_I && a != 5'd0);
      end
    end
    return hz.ex_is_load && hit;
  endfunction

  function automatic int run_pattern();
    if (hz.ex_br_taken) return P_FLUSH;
    if (model_lu())     return P_LU;
    return P_NORMAL;
  endfunction

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                        input logic f1, input logic f2, input logic [4:0] rd, input logic wi,
                        input logic wf, input logic ld, input logic br, input logic rq,
                        input logic ak);
    hz.id_rs1_addr = a1;  hz.id_rs2_addr = a2;
    hz.id_rs1_used = u1;  hz.id_rs2_used = u2;
    hz.id_rs1_is_f = f1;  hz.id_rs2_is_f = f2;
    hz.ex_rd_addr  = rd;  hz.ex_rd_wren_I = wi; hz.ex_rd_wren_F = wf;
    hz.ex_is_load  = ld;  hz.ex_br_taken = br;
    hz.mem_req     = rq;  hz.mem_ack = ak;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: queue this cycle's expected outputs, let the edge happen, advance the model.
  task automatic step();
    int         p;
    bit         err = 1'b0;
    logic [1:0] st;
    logic [8:0] pb;
    logic       r  = rst;
    st = (m_init_left > 0) ? 2'b00 : (m_waiting ? 2'b10 : 2'b01);
    if (r || m_init_left > 0) p = P_CLEAR;
    else if (!m_waiting) p = (hz.mem_req && !hz.mem_ack) ? P_WAIT : run_pattern();
    else if (hz.mem_ack) p = run_pattern();
    else if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
      p   = run_pattern();
      err = 1'b1;
    end else p = P_WAIT;
    pb = pat_bits(p);
    exp_q.push_back({pb, err, CNT_W'(m_stall), CNT_W'(m_flush), st});
    @(posedge clk);
    if (r) begin
      m_init_left = INIT_CYCLES;
      m_waiting = 1'b0;
      m_waited  = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (!pb[8] && m_stall < CNT_MAX) m_stall++;
      if (p == P_FLUSH && m_flush < CNT_MAX) m_flush++;
      if (p == P_WAIT) begin
        m_waited  = m_waiting ? m_waited + 1 : 1;
        m_waiting = 1'b1;
      end else begin
        m_waiting = 1'b0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {hz.pc_en, hz.sel_if_id, hz.sel_id_ex, hz.sel_ex_mem, hz.sel_mem_wb,
           hz.err_timeout, hz.stall_cnt, hz.flush_cnt, hz.state_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t pc/sel=%b err=%b stall=%0d flush=%0d st=%b (required pc/sel=%b err=%b stall=%0d flush=%0d st=%b)",
                 $time, a[W-1-:9], a[W-10], a[2*CNT_W+1-:CNT_W], a[CNT_W+1-:CNT_W], a[1:0],
                 e[W-1-:9], e[W-10], e[2*CNT_W+1-:CNT_W], e[CNT_W+1-:CNT_W], e[1:0]);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    // Integer load-use on rs2, then x0 (no hazard), then f0 via FP file (hazard).
    set_in(5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    idle(); step();
    set_in(5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    set_in(5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
    // Branch together with load-use: flush wins.
    set_in(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
    idle(); step();
    // Slow access acked on the 4th cycle, then again with a pending branch.
    for (int k = 0; k < 2; k++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, k[0], 1'b1, 1'b0);
      repeat (3) step();
      hz.mem_ack = 1'b1; step();
      idle(); step();
    end
    // Never-acked access: forced release.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) step();
    idle(); step();
    // Enough load-use stalls to saturate the counter.
    set_in(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    // Reset in the middle of a wait, and again in the middle of INIT.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0; idle(); repeat (3) step();
    // Random traffic over small address ranges so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0));
      step();
    end
    rst = 1'b0;
    idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32IF pipeline. Each cycle it drives the 2-bit select of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. It resolves load-use hazards on both the integer and FP register files, branch redirects from EX, and multi-cycle memory/peripheral (keypad) waits in MEM. It also keeps saturating stall and flush counters for debug.

## Interface
- INIT_CYCLES, 2: bubble cycles forced after reset release (≥1)
- TIMEOUT, 1024: max MEM_WAIT cycles before forced release; 0 disables timeout
- CNT_W, 32: width of performance counters
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- id_rs1_addr, id_rs2_addr  in  5 each  source register addresses of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rs1_is_f, id_rs2_is_f  in  1 each  source comes from the FP file (0 = integer file)
- ex_rd_addr  in  5  destination of the instruction in EX
- ex_rd_wren_I, ex_rd_wren_F  in  1 each  EX instruction writes integer / FP file
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch/jump (redirect)
- mem_req  in  1  MEM instruction accesses a slow target
- mem_ack  in  1  slow target completes this cycle
- pc_en  out  1  PC update enable
- sel_if_id, sel_id_ex, sel_ex_mem, sel_mem_wb  out  2 each  00 = load, 01 = hold, 11 = clear; 10 is never driven
- err_timeout  out  1  one-cycle pulse on forced MEM_WAIT release
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters
- state_o  out  2  00 INIT, 01 RUN, 10 MEM_WAIT

## Operation
- Load-use hazard (LU): ex_is_load and, for either source with used=1 and address = ex_rd_addr, one of these holds:
  - is_f=0, ex_rd_wren_I=1, address ≠ 0 (x0 never hazards)
  - is_f=1, ex_rd_wren_F=1 (f0 does hazard)
- Output patterns, in order pc_en / IF_ID / ID_EX / EX_MEM / MEM_WB:
  - NORMAL: 1/00/00/00/00
  - LU: 0/01/11/00/00 (one bubble)
  - FLUSH: 1/11/11/00/00 (PC loads redirect target)
  - WAIT: 0/01/01/01/11 (WB gets a bubble so there is no double write)
  - CLEAR: 0/11/11/11/11
- Pattern priority in RUN: WAIT (mem_req & !mem_ack) > FLUSH (ex_br_taken) > LU > NORMAL.
  - Branch plus LU in the same cycle gives FLUSH, because the ID instruction is wrong-path.
- FSM:
  - INIT: output CLEAR; counts INIT_CYCLES cycles, then goes to RUN.
  - RUN: outputs follow the priority above. mem_req & !mem_ack moves to MEM_WAIT, with the WAIT pattern already driven that cycle. mem_req & mem_ack stays in RUN with no stall.
  - MEM_WAIT: wait timer increments each cycle.
    - mem_ack=1: outputs follow RUN priority with the WAIT term excluded, then go to RUN.
    - Timer = TIMEOUT (≠0) without ack: same outputs as an ack, err_timeout=1, then go to RUN.
    - Otherwise: WAIT pattern.
- A branch pending in EX during MEM_WAIT is frozen (EX held) and is serviced on the release cycle.
- Timer clears on MEM_WAIT entry.
- stall_cnt: +1 on every cycle in RUN/MEM_WAIT with pc_en=0. flush_cnt: +1 on every FLUSH cycle. Both hold at all-ones and are not incremented in INIT.

## Timing
- Outputs are Mealy: combinational from registered state plus current inputs, with zero-cycle latency from hazard inputs.
- While i_rst=1: outputs CLEAR, err_timeout=0. On the next edge: state=INIT, INIT counter=0, wait timer=0, stall_cnt=flush_cnt=0, state_o=00.
- First RUN cycle is INIT_CYCLES cycles after the first edge with i_rst=0.
- i_rst asserted mid-MEM_WAIT or mid-INIT aborts immediately. No err_timeout is generated.
- LU costs exactly 1 cycle (the bubble removes the match). FLUSH costs 2 wrong-path slots. WAIT costs N cycles for ack N cycles after the request.
- err_timeout is high only in the forced-release cycle.

## Test plan
- Reset: i_rst=1 for 3 cycles, then 0 → CLEAR for 2 cycles, state_o=00 → 01 on cycle 3, counters 0.
- LU: ex_is_load=1, ex_rd_addr=5, wren_I=1, id_rs2_addr=5, used → one cycle of 0/01/11/00/00, stall_cnt=1. Repeat with addr=0 → NORMAL. Repeat with FP rd=0 (f0) and id_rs1_is_f=1 → LU.
- Branch: ex_br_taken=1 simultaneous with LU → FLUSH pattern, flush_cnt=1, stall_cnt unchanged.
- Keypad wait: mem_req=1, mem_ack rises on the 4th cycle → 3 WAIT cycles, then release, stall_cnt=3. Pending ex_br_taken held through the wait → FLUSH on the release cycle.
- Timeout: TIMEOUT=8, mem_ack never asserts → 8 WAIT cycles, err_timeout pulse on the 9th, state_o back to 01.
- Saturation: CNT_W=4, 20 LU stalls → stall_cnt=15.
